// File: rtl/accum_stage.sv
// accum_stage: sequential reduction stage behind the 32-bit multiplier.
// It accepts LEN products over a valid/ready handshake and sums them
// modulo 2^WIDTH. The carry is dropped, which is the same wrap rule the
// combinational adder uses. The stage then holds one registered result
// until downstream takes it.
module accum_stage #(
   parameter int WIDTH = 32,
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic             accept;
   logic             last_term;

   // A term is taken only while accumulating. in_ready comes from the state alone.
   assign accept    = in_valid && (state_q == ACCUM);
   assign last_term = (cnt_q == LEN_W'(1));

   // State, accumulator and remaining-count registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments, so every register updates from pre-edge values.
      if (reset) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic. start is only looked at in IDLE; a start in any other state is dropped.
   always_comb begin
      // NOTE: the default assignment first means every path assigns state_d, so no latch is inferred.
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = (len == '0) ? DONE : ACCUM;
            end
         end
         ACCUM: begin
            if (accept && last_term) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath. Clear and load on start, then add each accepted term with the carry dropped.
   always_comb begin
      acc_d = acc_q;
      cnt_d = cnt_q;
      if ((state_q == IDLE) && start) begin
         acc_d = '0;
         if (len != '0) begin
            cnt_d = len;
         end
      end else if (accept) begin
         acc_d = acc_q + in_data;
         cnt_d = cnt_q - LEN_W'(1);
      end
   end

   // Outputs are decoded from registered state only. out_data is the accumulator itself.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      unique case (state_q)
         IDLE:  ;
         ACCUM: begin
            in_ready = 1'b1;
            busy     = 1'b1;
         end
         DONE: begin
            out_valid = 1'b1;
            busy      = 1'b1;
         end
         default: ;
      endcase
      out_data = acc_q;
   end

endmodule

// File: tb/tb_accum_stage.sv
// tb_accum_stage: directed, scoreboard-based bench for accum_stage.
// Each test pushes the sum it expects when it drives a job. It pops and
// compares that sum when the result appears. Inputs change and outputs
// are sampled on the falling edge.
module tb_accum_stage;

   localparam int WIDTH = 32;
   localparam int LEN_W = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [LEN_W-1:0] len;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;
   logic             busy;

   int n_checks = 0;
   int n_fail   = 0;
   logic [WIDTH-1:0] exp_q[$];

   accum_stage #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .len       (len),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [WIDTH-1:0] pop_exp();
      if (exp_q.size() == 0) return 'x;
      return exp_q.pop_front();
   endfunction

   // Called at a falling edge. Pulses start for one rising edge and returns at the next falling edge.
   task automatic start_job(input logic [LEN_W-1:0] l);
      start = 1'b1;
      len   = l;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Called at a falling edge. Presents one term, waits (bounded) for in_ready, and returns after the accept edge.
   task automatic send_term(input logic [WIDTH-1:0] d, output bit ok);
      int t = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      ok = (in_ready === 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output bit ok);
      int t = 0;
      while (out_valid !== 1'b1 && t < 100) begin
         @(negedge clk);
         t++;
      end
      ok = (out_valid === 1'b1);
   endtask

   // Takes the result at the next rising edge and returns at the falling edge after it.
   task automatic accept_out();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({in_ready, out_valid, busy} !== 3'b000) begin
         n_fail++; $display("FAIL reset_ctrl: got %b want 000", {in_ready, out_valid, busy});
      end
      n_checks++;
      if (out_data !== '0) begin
         n_fail++; $display("FAIL reset_data: got %h want 0", out_data);
      end
   endtask

   task automatic test_basic();
      logic [WIDTH-1:0] terms[3] = '{32'd2, 32'd5, 32'd7};
      logic [WIDTH-1:0] sum = '0;
      bit ok;
      foreach (terms[i]) sum += terms[i];
      exp_q.push_back(sum);
      start_job(8'd3);
      n_checks++;
      if (busy !== 1'b1 || in_ready !== 1'b1) begin
         n_fail++; $display("FAIL basic_busy: busy=%b in_ready=%b want 1 1", busy, in_ready);
      end
      foreach (terms[i]) begin
         send_term(terms[i], ok);
         n_checks++;
         if (!ok) begin n_fail++; $display("FAIL basic_in_ready: term %0d never accepted", i); end
         if (i < 2) begin
            n_checks++;
            if (out_valid !== 1'b0) begin
               n_fail++; $display("FAIL basic_early_valid: got %b want 0 after term %0d", out_valid, i);
            end
         end
      end
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
         n_fail++; $display("FAIL basic_latency: out_valid=%b in_ready=%b want 1 0", out_valid, in_ready);
      end
      n_checks++;
      if (out_data !== pop_exp()) begin
         n_fail++; $display("FAIL basic_sum: got %0d want 14", out_data);
      end
      accept_out();
      n_checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL basic_release: out_valid=%b busy=%b want 0 0", out_valid, busy);
      end
   endtask

   task automatic test_wrap();
      bit ok1, ok2, okv;
      exp_q.push_back(32'hFFFF_FFFF + 32'h0000_0003);
      start_job(8'd2);
      send_term(32'hFFFF_FFFF, ok1);
      send_term(32'h0000_0003, ok2);
      wait_out(okv);
      n_checks++;
      if (!(ok1 && ok2 && okv)) begin
         n_fail++; $display("FAIL wrap_handshake: ok=%b%b%b want 111", ok1, ok2, okv);
      end
      n_checks++;
      if (out_data !== pop_exp()) begin
         n_fail++; $display("FAIL wrap_sum: got %h want 00000002", out_data);
      end
      accept_out();
   endtask

   task automatic test_bubbles_backpressure();
      logic [WIDTH-1:0] held;
      bit ok, okv;
      exp_q.push_back(32'd4 + 32'd5);
      start_job(8'd2);
      for (int k = 0; k < 2; k++) begin
         repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
               n_fail++; $display("FAIL bubble_state: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
            end
         end
         send_term((k == 0) ? 32'd4 : 32'd5, ok);
         n_checks++;
         if (!ok) begin n_fail++; $display("FAIL bubble_accept: term %0d not accepted", k); end
      end
      wait_out(okv);
      held = out_data;
      n_checks++;
      if (!okv || held !== pop_exp()) begin
         n_fail++; $display("FAIL bubble_sum: valid=%b got %0d want 9", okv, held);
      end
      // Offer a stray product while the result is held. It must not be consumed.
      in_valid = 1'b1; in_data = 32'd100;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         n_checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== held) begin
            n_fail++; $display("FAIL hold_stable: cyc %0d valid=%b in_ready=%b data=%0d want 1 0 %0d",
                               c, out_valid, in_ready, out_data, held);
         end
      end
      in_valid = 1'b0;
      accept_out();
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL hold_release: busy=%b want 0", busy); end
   endtask

   task automatic test_zero_len();
      exp_q.push_back('0);
      in_valid = 1'b1; in_data = 32'h55;
      start_job(8'd0);
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
         n_fail++; $display("FAIL zero_ctrl: valid=%b in_ready=%b busy=%b want 1 0 1", out_valid, in_ready, busy);
      end
      n_checks++;
      if (out_data !== pop_exp()) begin
         n_fail++; $display("FAIL zero_data: got %h want 0", out_data);
      end
      in_valid = 1'b0;
      accept_out();
   endtask

   task automatic test_ignored_start();
      bit ok1, ok2, ok3;
      exp_q.push_back(32'd10 + 32'd20 + 32'd30);
      start_job(8'd3);
      send_term(32'd10, ok1);
      start = 1'b1; len = 8'd7;
      @(negedge clk);
      start = 1'b0; len = 8'd1;
      send_term(32'd20, ok2);
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL ign_early: out_valid=%b want 0 after 2 terms", out_valid);
      end
      send_term(32'd30, ok3);
      n_checks++;
      if (!(ok1 && ok2 && ok3) || out_valid !== 1'b1) begin
         n_fail++; $display("FAIL ign_count: ok=%b%b%b valid=%b want 111 1", ok1, ok2, ok3, out_valid);
      end
      n_checks++;
      if (out_data !== pop_exp()) begin
         n_fail++; $display("FAIL ign_sum: got %0d want 60", out_data);
      end
      len = '0;
      accept_out();
   endtask

   task automatic test_reset_mid_job();
      bit ok, okv;
      exp_q.push_back(32'd1 + 32'd2 + 32'd3 + 32'd4);
      start_job(8'd4);
      send_term(32'd1, ok);
      send_term(32'd2, ok);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
      n_checks++;
      if ({in_ready, out_valid, busy} !== 3'b000 || out_data !== '0) begin
         n_fail++; $display("FAIL midreset_outputs: ctrl=%b data=%h want 000 0",
                            {in_ready, out_valid, busy}, out_data);
      end
      exp_q.push_back(32'd9);
      start_job(8'd1);
      send_term(32'd9, ok);
      wait_out(okv);
      n_checks++;
      if (!okv || out_data !== pop_exp()) begin
         n_fail++; $display("FAIL midreset_newjob: valid=%b got %0d want 9", okv, out_data);
      end
      accept_out();
   endtask

   task automatic test_back_to_back();
      bit ok, okv;
      for (int j = 0; j < 2; j++) begin
         exp_q.push_back(32'(j + 3));
         start_job(8'd1);
         n_checks++;
         if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_start: job %0d busy=%b want 1", j, busy); end
         send_term(32'(j + 3), ok);
         wait_out(okv);
         n_checks++;
         if (!okv || out_data !== pop_exp()) begin
            n_fail++; $display("FAIL b2b_sum: job %0d got %0d want %0d", j, out_data, j + 3);
         end
         accept_out();
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++; $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_bubbles_backpressure();
      test_zero_len();
      test_ignored_start();
      test_reset_mid_job();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
